// File: rtl/instr_fetch1_buf_pkg.sv
// Shared fetch-pipeline types: default fetch geometry, lane mask and the
// {pc, mask} record that Fetch1 queues for Fetch2.
package fetch_pkg;

   localparam int FETCH_WIDTH_DEF = 4;
   localparam int PC_W_DEF        = 32;

   typedef logic [PC_W_DEF-1:0]        program_counter_t;
   typedef logic [FETCH_WIDTH_DEF-1:0] fetch_mask_t;

   typedef struct packed {
      program_counter_t pc;
      fetch_mask_t      mask;
   } fetch1_entry_t;

   // Pointer width for a DEPTH-entry ring; a 1-entry ring still gets one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/instr_fetch1_buf_if.sv
// Fetch1 bus bundle: PC generator handshake, ITLB/ITag read strobes and the
// Fetch2 valid/stall head. With FETCH1_PERF_EN defined it also carries the
// blocked-cycle perf counter.
interface instr_fetch1_buf_if #(
   parameter int FETCH_WIDTH = 4,
   parameter int PC_W        = 32
);
   logic                   i_flush;
   logic                   i_pc_valid;
   logic [PC_W-1:0]        i_pc;
   logic                   o_pc_ready;
   logic                   i_itlb_avail;
   logic                   o_itlb_read;
   logic                   i_icache_tag_avail;
   logic                   o_icache_tag_read;
   logic                   i_stall;
   logic                   o_valid;
   logic [PC_W-1:0]        o_pc;
   logic [FETCH_WIDTH-1:0] o_mask;
`ifdef FETCH1_PERF_EN
   logic [31:0]            o_blocked_cycles;
`endif

   // Fetch1 side.
   modport slave (
      input  i_flush, i_pc_valid, i_pc, i_itlb_avail, i_icache_tag_avail, i_stall,
      output o_pc_ready, o_itlb_read, o_icache_tag_read, o_valid, o_pc, o_mask
`ifdef FETCH1_PERF_EN
      , output o_blocked_cycles
`endif
   );

   // Surrounding pipeline side.
   modport master (
      output i_flush, i_pc_valid, i_pc, i_itlb_avail, i_icache_tag_avail, i_stall,
      input  o_pc_ready, o_itlb_read, o_icache_tag_read, o_valid, o_pc, o_mask
`ifdef FETCH1_PERF_EN
      , input o_blocked_cycles
`endif
   );

endinterface

// File: rtl/instr_fetch1_buf_skid_fifo.sv
// fetch1_skid_fifo: DEPTH-entry in-order ring of issued fetch entries.
// Flush/reset zero the pointers and count; storage is cleared on reset only.
module fetch1_skid_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = fetch1_entry_t
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  entry_t                     i_data,
   output entry_t                     o_head,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   // Storage: cleared on reset so an empty head reads zero, else written at the tail.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (i_push && !i_flush) begin
         mem[wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy; flush beats any push or pop in the same cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (i_push) wr_ptr <= next_ptr(wr_ptr);
         if (i_pop)  rd_ptr <= next_ptr(rd_ptr);
         count <= count + CW'(i_push) - CW'(i_pop);
      end
   end

   assign o_head  = mem[rd_ptr];
   assign o_count = count;

endmodule

// File: rtl/instr_fetch1_buf.sv
// instr_fetch1_buf: fetch stage 1. Issues ITLB/ITag reads for accepted PCs,
// builds the lane mask and queues {pc, mask} for Fetch2 in a skid FIFO.
// Optional feature macro: FETCH1_PERF_EN (adds o_blocked_cycles).
//
// Handshakes: a PC is taken only in a cycle where i_pc_valid and o_pc_ready
// are both 1 (o_pc_ready is combinational and equals the read strobes);
// an entry leaves toward Fetch2 only in a cycle where o_valid is 1 and
// i_stall is 0, and the head holds steady otherwise.
module instr_fetch1_buf
   import fetch_pkg::*;
#(
   parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
   parameter int DEPTH       = 2,
   parameter int PC_W        = PC_W_DEF
) (
   input logic               i_clk,
   input logic               i_rst_n,
   instr_fetch1_buf_if.slave bus
);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Same layout as fetch1_entry_t, sized by this instance's parameters.
   typedef struct packed {
      logic [PC_W-1:0]        pc;
      logic [FETCH_WIDTH-1:0] mask;
   } entry_t;

   logic                   valid;
   logic                   drain;
   logic                   pop;
   logic                   space;
   logic                   issue;
   logic [CW-1:0]          count;
   logic [FETCH_WIDTH-1:0] push_mask;
   entry_t                 push_entry;
   entry_t                 head;

   assign valid = (count != '0);
   assign drain = valid & ~bus.i_stall;
   // A pop during flush is dropped along with the rest of the queue.
   assign pop   = drain & ~bus.i_flush;
   // Full is fine when the head leaves this same cycle.
   assign space = (count < DEPTH_C) | drain;
   assign issue = bus.i_pc_valid & bus.i_itlb_avail & bus.i_icache_tag_avail
                & space & ~bus.i_flush & i_rst_n;

   if (FETCH_WIDTH > 1) begin : g_mask
      localparam int OW = $clog2(FETCH_WIDTH);
      logic [OW-1:0] off;
      assign off = bus.i_pc[OW+1:2];
      // Lanes at or after the PC's slot in the aligned block are live.
      always_comb begin
         push_mask = '0;
         for (int k = 0; k < FETCH_WIDTH; k++) push_mask[k] = (k >= int'(off));
      end
   end else begin : g_mask1
      assign push_mask = 1'b1;
   end

   assign push_entry.pc   = bus.i_pc;
   assign push_entry.mask = push_mask;

   fetch1_skid_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (bus.i_flush),
      .i_push  (issue),
      .i_pop   (pop),
      .i_data  (push_entry),
      .o_head  (head),
      .o_count (count)
   );

   assign bus.o_pc_ready        = issue;
   assign bus.o_itlb_read       = issue;
   assign bus.o_icache_tag_read = issue;
   assign bus.o_valid           = valid;
   assign bus.o_pc              = head.pc;
   assign bus.o_mask            = head.mask;

`ifdef FETCH1_PERF_EN
   logic [31:0] blocked_q;

   // Saturating count of offered-but-not-taken cycles; only reset clears it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         blocked_q <= '0;
      end else if (bus.i_pc_valid && !issue && !bus.i_flush && (blocked_q != 32'hFFFF_FFFF)) begin
         blocked_q <= blocked_q + 32'd1;
      end
   end

   assign bus.o_blocked_cycles = blocked_q;
`endif

endmodule

// File: tb/tb_instr_fetch1_buf.sv
// Directed bench for instr_fetch1_buf (FETCH_WIDTH=4, DEPTH=2, PC_W=32).
// The driver pushes hand-computed {pc, mask} entries for every expected issue;
// a monitor pops and compares whenever Fetch2 takes the head.
module tb_instr_fetch1_buf;
   import fetch_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   instr_fetch1_buf_if #(.FETCH_WIDTH(4), .PC_W(32)) bus ();

   instr_fetch1_buf #(.FETCH_WIDTH(4), .DEPTH(2), .PC_W(32)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // Clock / reset
   always #5 clk = ~clk;

   logic [35:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Driver: apply one cycle of inputs, check strobes, record expected entry.
   task automatic step(input logic v, input logic [31:0] pc, input logic tlb, input logic tag,
                       input logic stall, input logic flush, input logic rst,
                       input logic exp_rdy, input logic [3:0] exp_mask, input string name);
      @(posedge clk); #1;
      bus.i_pc_valid         = v;
      bus.i_pc               = pc;
      bus.i_itlb_avail       = tlb;
      bus.i_icache_tag_avail = tag;
      bus.i_stall            = stall;
      bus.i_flush            = flush;
      rst_n                  = rst;
      @(negedge clk);
      check({name, "_strobes"}, {61'd0, bus.o_pc_ready, bus.o_itlb_read, bus.o_icache_tag_read},
            exp_rdy ? 64'd7 : 64'd0);
      if (!rst || flush) exp_q.delete();
      if (exp_rdy) exp_q.push_back({pc, exp_mask});
   endtask

   task automatic offer(input logic [31:0] pc, input logic stall, input logic exp_rdy,
                        input logic [3:0] exp_mask, input string name);
      step(1'b1, pc, 1'b1, 1'b1, stall, 1'b0, 1'b1, exp_rdy, exp_mask, name);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, name);
         n++;
      end
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_valid"}, {63'd0, bus.o_valid}, 64'd0);
      check({name, "_pc"}, {32'd0, bus.o_pc}, 64'd0);
      check({name, "_mask"}, {60'd0, bus.o_mask}, 64'd0);
`ifdef FETCH1_PERF_EN
      check({name, "_blocked"}, {32'd0, bus.o_blocked_cycles}, 64'd0);
`endif
   endtask

   // Scoreboard monitor: every accepted head must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && !bus.i_flush && bus.o_valid && !bus.i_stall) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL pop_unexpected: got pc=%0h mask=%0h expected no entry", bus.o_pc, bus.o_mask);
         end else begin
            logic [35:0] e;
            e = exp_q.pop_front();
            check("pop_pc", {32'd0, bus.o_pc}, {32'd0, e[35:4]});
            check("pop_mask", {60'd0, bus.o_mask}, {60'd0, e[3:0]});
         end
      end
   end

   initial begin
      bus.i_pc_valid         = 1'b0;
      bus.i_pc               = '0;
      bus.i_itlb_avail       = 1'b1;
      bus.i_icache_tag_avail = 1'b1;
      bus.i_stall            = 1'b0;
      bus.i_flush            = 1'b0;

      // Reset with a PC on offer: no strobes, all outputs zero.
      step(1'b1, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, "rst0");
      step(1'b1, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, "rst1");
      check_zero_outputs("reset");

      // 1: one issue per cycle, one-cycle latency to the head.
      offer(32'h1000, 1'b0, 1'b1, 4'b1111, "t1_a");
      check("t1_empty", {63'd0, bus.o_valid}, 64'd0);
      offer(32'h1010, 1'b0, 1'b1, 4'b1111, "t1_b");
      check("t1_latency", {31'd0, bus.o_valid, bus.o_pc}, {31'd0, 1'b1, 32'h1000});
      offer(32'h1020, 1'b0, 1'b1, 4'b1111, "t1_c");
      offer(32'h1030, 1'b0, 1'b1, 4'b1111, "t1_d");
      drain("t1");

      // 2: lane masks for unaligned entry points.
      offer(32'h2008, 1'b0, 1'b1, 4'b1100, "t2_a");
      offer(32'h200C, 1'b0, 1'b1, 4'b1000, "t2_b");
      offer(32'h2004, 1'b0, 1'b1, 4'b1110, "t2_c");
      drain("t2");

      // 4: ITLB unavailable for 3 cycles, then the same PC issues once.
      step(1'b1, 32'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "t4_blk0");
      step(1'b1, 32'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "t4_blk1");
      step(1'b1, 32'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "t4_blk2");
      offer(32'h4000, 1'b0, 1'b1, 4'b1111, "t4_go");
`ifdef FETCH1_PERF_EN
      check("t4_blocked", {32'd0, bus.o_blocked_cycles}, 64'd3);
`endif
      drain("t4");

      // 3: stall fills both entries, then release does push+pop at full.
      offer(32'h3000, 1'b1, 1'b1, 4'b1111, "t3_a");
      offer(32'h3010, 1'b1, 1'b1, 4'b1111, "t3_b");
      offer(32'h3020, 1'b1, 1'b0, 4'h0, "t3_full0");
      offer(32'h3020, 1'b1, 1'b0, 4'h0, "t3_full1");
      offer(32'h3020, 1'b1, 1'b0, 4'h0, "t3_full2");
      check("t3_hold", {31'd0, bus.o_valid, bus.o_pc}, {31'd0, 1'b1, 32'h3000});
      offer(32'h3020, 1'b0, 1'b1, 4'b1111, "t3_release");
      offer(32'h3030, 1'b0, 1'b1, 4'b1111, "t3_d");
`ifdef FETCH1_PERF_EN
      check("t3_blocked", {32'd0, bus.o_blocked_cycles}, 64'd6);
`endif
      drain("t3");

      // 5: flush with two queued entries drops them; next PC issues right after.
      offer(32'h5000, 1'b1, 1'b1, 4'b1111, "t5_a");
      offer(32'h5010, 1'b1, 1'b1, 4'b1111, "t5_b");
      step(1'b1, 32'h5020, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, "t5_flush");
      offer(32'h5020, 1'b0, 1'b1, 4'b1111, "t5_after");
      check("t5_flushed", {63'd0, bus.o_valid}, 64'd0);
`ifdef FETCH1_PERF_EN
      check("t5_blocked", {32'd0, bus.o_blocked_cycles}, 64'd6);
`endif
      drain("t5");

      // 6: one-cycle reset mid-stream drops queued PCs.
      offer(32'h6000, 1'b1, 1'b1, 4'b1111, "t6_a");
      offer(32'h6010, 1'b1, 1'b1, 4'b1111, "t6_b");
      step(1'b1, 32'h6020, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, "t6_rst");
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "t6_idle");
      check_zero_outputs("t6_post_rst");
      offer(32'h6034, 1'b0, 1'b1, 4'b1110, "t6_c");
      drain("t6");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
